// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator sequencer: opcode values and FSM states.
package accum_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LOAD  = 4'd0;
  localparam logic [OPC_W-1:0] OP_STORE = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADDI  = 4'd2;
  localparam logic [OPC_W-1:0] OP_INCP  = 4'd3;
  localparam logic [OPC_W-1:0] OP_SETP  = 4'd4;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'd5;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'd6;
  localparam logic [OPC_W-1:0] OP_NOP   = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM,
    HALT
  } state_e;

endpackage

// File: rtl/step_divider.sv
// Free-running pacing counter: one tick every DIV+1 clocks (DIV=0 ticks every clock).
module step_divider #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    tick    = (count_q == CNT_MAX);
    count_d = tick ? '0 : count_q + 1'b1;
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/accum_core.sv
// Accumulator sequencer: fetch/decode/memory FSM paced by step_divider, one acc and one dptr.
module accum_core
  import accum_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15,
  parameter int START_ADDR = 9216,
  parameter int DATA_LIMIT = 8000,
  parameter int DIV        = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic [DATA_W-1:0] datain,
  input  logic              ready,
  output logic [ADDR_W-1:0] addrout,
  output logic [DATA_W-1:0] dataout,
  output logic              req,
  output logic              we,
  output logic              halted,
  output logic              illegal
);

  localparam int IMM_W = DATA_W - OPC_W;
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DATA_LIMIT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] dptr_q, dptr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              illegal_q, illegal_d;
  logic              tick;
  logic [OPC_W-1:0]  opcode;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W:0]   incp_sum;

  step_divider #(.DIV(DIV)) u_step_divider (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign opcode   = instr_q[DATA_W-1 -: OPC_W];
  assign imm      = instr_q[IMM_W-1:0];
  // One extra bit keeps the carry so an overflowing INCP still compares above the limit.
  assign incp_sum = {1'b0, dptr_q} + (ADDR_W + 1)'(imm);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dptr_d    = dptr_q;
    acc_d     = acc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    req       = 1'b0;
    we        = 1'b0;
    addrout   = pc_q;

    unique case (state_q)
      IDLE: if (tick && run) state_d = FETCH;

      FETCH: begin
        req = 1'b1;
        if (tick && ready) begin
          instr_d = datain;
          state_d = DECODE;
        end
      end

      DECODE: if (tick) begin
        state_d = run ? FETCH : IDLE;
        pc_d    = pc_q + 1'b1;
        case (opcode)
          OP_LOAD, OP_STORE: begin
            state_d = MEM;
            pc_d    = pc_q;
          end
          OP_ADDI: acc_d  = acc_q + DATA_W'(imm);
          OP_INCP: dptr_d = (incp_sum > LIMIT) ? '0 : incp_sum[ADDR_W-1:0];
          OP_SETP: dptr_d = ADDR_W'(imm);
          OP_JMP:  pc_d   = START + ADDR_W'(imm);
          OP_HALT: begin
            state_d = HALT;
            pc_d    = pc_q;
          end
          OP_NOP:  ;
          default: illegal_d = 1'b1;
        endcase
      end

      MEM: begin
        addrout = dptr_q;
        req     = 1'b1;
        we      = (opcode == OP_STORE);
        if (tick && ready) begin
          if (opcode == OP_LOAD) acc_d = datain;
          pc_d    = pc_q + 1'b1;
          state_d = run ? FETCH : IDLE;
        end
      end

      HALT: ;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= START;
      dptr_q    <= '0;
      acc_q     <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dptr_q    <= dptr_d;
      acc_q     <= acc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  assign dataout = acc_q;
  assign illegal = illegal_q;
  assign halted  = (state_q == IDLE) || (state_q == HALT);

endmodule

// File: tb/tb_accum_core.sv
// Bench for accum_core: instruction-level reference model checked on every bus cycle,
// plus directed programs and a DIV=10 pacing check on a second instance.
module tb_accum_core;

  localparam int START = 9216;
  localparam int LIMIT = 8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        run_s = 1'b0;
  logic        ready = 1'b0;
  logic        ready_s = 1'b1;
  logic [15:0] junk = 16'h0;
  logic [15:0] datain_s = 16'h7000;
  logic [15:0] mem [0:32767];
  logic [15:0] prog [$];

  logic [14:0] addrout, addrout_s;
  logic [15:0] dataout, dataout_s;
  logic        req, we, halted, illegal;
  logic        req_s, we_s, halted_s, illegal_s;
  logic [15:0] datain;

  assign datain = ready ? mem[addrout] : junk;

  accum_core #(.DIV(0)) u_dut (
    .clock (clk), .reset_n (reset_n), .run (run), .datain (datain), .ready (ready),
    .addrout (addrout), .dataout (dataout), .req (req), .we (we),
    .halted (halted), .illegal (illegal)
  );

  accum_core #(.DIV(10)) u_dut_slow (
    .clock (clk), .reset_n (reset_n), .run (run_s), .datain (datain_s), .ready (ready_s),
    .addrout (addrout_s), .dataout (dataout_s), .req (req_s), .we (we_s),
    .halted (halted_s), .illegal (illegal_s)
  );

  int n_vec = 0;
  int n_miss = 0;
  int ready_mode = 0;  // 0 always, 1 random, 2 never, 3 stall write requests
  bit chk_en = 1'b0;

  // Instruction-level reference state
  int m_pc, m_dptr, m_acc, m_memop, n_wr, last_wr_addr;
  bit m_ill, m_halt, m_fetch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = START; m_dptr = 0; m_acc = 0; m_memop = 0;
    m_ill = 1'b0; m_halt = 1'b0; m_fetch = 1'b1;
    n_wr = 0; last_wr_addr = -1;
  endtask

  task automatic model_step(input logic [15:0] rd);
    int op, imm;
    op  = int'(rd[15:12]);
    imm = int'(rd[11:0]);
    if (!m_fetch) begin
      if (m_memop == 0) m_acc = int'(rd);
      m_pc = (m_pc + 1) % 32768;
      m_fetch = 1'b1;
    end else begin
      case (op)
        0, 1: begin m_memop = op; m_fetch = 1'b0; end
        2: begin m_acc = (m_acc + imm) % 65536; m_pc = (m_pc + 1) % 32768; end
        3: begin m_dptr = (m_dptr + imm > LIMIT) ? 0 : m_dptr + imm; m_pc = (m_pc + 1) % 32768; end
        4: begin m_dptr = imm; m_pc = (m_pc + 1) % 32768; end
        5: m_pc = (START + imm) % 32768;
        6: m_halt = 1'b1;
        7: m_pc = (m_pc + 1) % 32768;
        default: begin m_ill = 1'b1; m_pc = (m_pc + 1) % 32768; end
      endcase
    end
  endtask

  // Memory responder pacing
  always @(posedge clk) begin
    #1;
    junk = 16'($urandom);
    case (ready_mode)
      0: ready = 1'b1;
      1: ready = ($urandom_range(0, 9) < 7);
      3: ready = !we;
      default: ready = 1'b0;
    endcase
  end

  // Compare process: every request cycle must match the model's pending bus access
  always @(negedge clk) begin
    if (reset_n && chk_en && req) begin
      if (m_halt) begin
        check("req_after_halt", 32'(req), 32'd0);
      end else begin
        check("addrout", 32'(addrout), 32'(m_fetch ? m_pc : m_dptr));
        check("we", 32'(we), 32'(!m_fetch && m_memop == 1));
        if (!m_fetch && m_memop == 1) check("dataout", 32'(dataout), 32'(m_acc));
        check("illegal", 32'(illegal), 32'(m_ill));
        check("halted_busy", 32'(halted), 32'd0);
        if (ready) begin
          if (we) begin
            mem[addrout] = dataout;
            n_wr++;
            last_wr_addr = int'(addrout);
          end
          model_step(datain);
        end
      end
    end
  end

  task automatic load_prog();
    foreach (prog[i]) mem[START + i] = prog[i];
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    run = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (m_halt && halted) begin done = 1'b1; break; end
    end
    check("halt_reached", 32'(done), 32'd1);
    check("final_pc", 32'(addrout), 32'(m_pc));
    check("final_illegal", 32'(illegal), 32'(m_ill));
  endtask

  task automatic wait_write_req(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (req && we) begin done = 1'b1; break; end
    end
    check("store_req_seen", 32'(done), 32'd1);
  endtask

  initial begin
    bit done;
    model_reset();

    // Pacing with DIV=10: run rises with reset release; ready tied high, NOPs fetched
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_s = 1'b1;
    check("slow_reset_addr", 32'(addrout_s), 32'(START));
    check("slow_reset_halted", 32'(halted_s), 32'd1);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      check("slow_req", 32'(req_s), 32'((k >= 11 && k < 22) || k >= 33));
      if (k == 11) check("slow_fetch0_addr", 32'(addrout_s), 32'(START));
      if (k == 33) check("slow_fetch1_addr", 32'(addrout_s), 32'(START + 1));
    end
    check("slow_we", 32'(we_s), 32'd0);
    check("slow_illegal", 32'(illegal_s), 32'd0);
    check("slow_acc", 32'(dataout_s), 32'd0);
    run_s = 1'b0;

    // Reset values of the DIV=0 core
    do_reset();
    #1;
    check("rst_req", 32'(req), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_addrout", 32'(addrout), 32'(START));
    check("rst_acc", 32'(dataout), 32'd0);

    // SETP 5, ADDI 3, STORE, HALT
    mem[5] = 16'h0;
    prog = '{16'h4005, 16'h2003, 16'h1000, 16'h6000};
    load_prog();
    ready_mode = 0;
    do_reset();
    run = 1'b1;
    wait_halt(200);
    check("t1_mem5", 32'(mem[5]), 32'h3);
    check("t1_pc", 32'(addrout), 32'd9219);
    check("t1_illegal", 32'(illegal), 32'd0);
    repeat (5) @(negedge clk);
    check("t1_halt_sticky", 32'(halted), 32'd1);
    check("t1_halt_noreq", 32'(req), 32'd0);

    // SETP 7, LOAD, ADDI 1, STORE, HALT with mem[7]=0xAA
    mem[7] = 16'h00AA;
    prog = '{16'h4007, 16'h0000, 16'h2001, 16'h1000, 16'h6000};
    load_prog();
    do_reset();
    run = 1'b1;
    wait_halt(200);
    check("t2_mem7", 32'(mem[7]), 32'h00AB);
    check("t2_one_write", 32'(n_wr), 32'd1);

    // dptr 7998 + 5 wraps to 0, JMP 7 skips a word, opcode 12 flags illegal
    mem[0] = 16'h5555;
    prog = '{16'h4FFF, 16'h3F3F, 16'h3005, 16'h2009, 16'h1000,
             16'h5007, 16'hC000, 16'hC123, 16'h6000};
    load_prog();
    do_reset();
    run = 1'b1;
    wait_halt(300);
    check("t3_mem0", 32'(mem[0]), 32'h9);
    check("t3_wr_addr", 32'(last_wr_addr), 32'd0);
    check("t3_illegal", 32'(illegal), 32'd1);
    check("t3_pc", 32'(addrout), 32'd9224);

    // FETCH held with ready low for 20 cycles
    prog = '{16'h7000, 16'h6000};
    load_prog();
    ready_mode = 2;
    do_reset();
    run = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (req) begin done = 1'b1; break; end
    end
    check("t4_fetch_started", 32'(done), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("t4_stall_req", 32'(req), 32'd1);
      check("t4_stall_addr", 32'(addrout), 32'(START));
    end
    ready_mode = 0;
    wait_halt(200);
    check("t4_pc", 32'(addrout), 32'd9217);

    // run drops while a STORE waits in MEM: store completes, then IDLE
    mem[5] = 16'h0;
    prog = '{16'h4005, 16'h2003, 16'h1000, 16'h6000};
    load_prog();
    ready_mode = 3;
    do_reset();
    run = 1'b1;
    wait_write_req(200);
    run = 1'b0;
    repeat (2) @(negedge clk);
    ready_mode = 0;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (!req && halted) begin done = 1'b1; break; end
    end
    check("t5_idle_reached", 32'(done), 32'd1);
    check("t5_mem5", 32'(mem[5]), 32'h3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("t5_idle_req", 32'(req), 32'd0);
      check("t5_idle_pc", 32'(addrout), 32'd9219);
    end
    run = 1'b1;
    wait_halt(200);
    check("t5_pc", 32'(addrout), 32'd9219);

    // reset asserted in the middle of a stalled STORE
    mem[5] = 16'h0;
    ready_mode = 3;
    do_reset();
    run = 1'b1;
    wait_write_req(200);
    chk_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_req_drop", 32'(req), 32'd0);
    check("t6_we_drop", 32'(we), 32'd0);
    check("t6_acc_clear", 32'(dataout), 32'd0);
    check("t6_halted", 32'(halted), 32'd1);
    check("t6_addr", 32'(addrout), 32'(START));
    check("t6_no_write", 32'(mem[5]), 32'h0);
    ready_mode = 0;
    do_reset();
    run = 1'b1;
    wait_halt(200);
    check("t6_mem5", 32'(mem[5]), 32'h3);

    // Random programs against the model, random ready
    for (int a = 0; a < 8192; a++) mem[a] = 16'($urandom);
    ready_mode = 1;
    for (int p = 0; p < 6; p++) begin
      prog.delete();
      for (int i = 0; i < 39; i++) begin
        int r;
        logic [11:0] imm;
        r = $urandom_range(0, 99);
        imm = 12'($urandom);
        if (r < 15)      prog.push_back(16'h0000);
        else if (r < 30) prog.push_back(16'h1000);
        else if (r < 50) prog.push_back({4'h2, imm});
        else if (r < 62) prog.push_back({4'h3, imm});
        else if (r < 72) prog.push_back({4'h4, imm});
        else if (r < 78) prog.push_back({4'h5, 12'($urandom_range(i + 1, 39))});
        else if (r < 86) prog.push_back({4'h7, imm});
        else if (r < 92) prog.push_back({4'($urandom_range(8, 15)), imm});
        else             prog.push_back({4'h2, imm});
      end
      prog.push_back(16'h6000);
      load_prog();
      do_reset();
      run = 1'b1;
      wait_halt(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/accum_core.md
Name: accum_core

Overview:
- Parametrised accumulator-style sequencer, successor to the fixed 4-opcode 16-bit core.
- Fetches instructions from the shared memory bus starting at START_ADDR and keeps one accumulator (acc) and one data pointer (dptr).
- Executes load/store/add/pointer/jump/halt operations through a ready-handshaked memory port.
- A programmable step divider paces execution for slow memories and visible demos.

Parameters:
- DATA_W, 16: data/instruction width (>=8).
- ADDR_W, 15: memory address width.
- START_ADDR, 9216: reset/jump base for the instruction pointer (pc).
- DATA_LIMIT, 8000: dptr wraps to 0 when an update would exceed this value.
- DIV, 10: step divider; FSM advances only on tick, one tick per DIV+1 clocks; 0 means every clock.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level enable; deassertion halts at the next instruction boundary.
- datain  in  DATA_W  memory read data, valid when ready=1.
- ready  in  1  memory completes the current request this cycle.
- addrout  out  ADDR_W  memory address.
- dataout  out  DATA_W  write data; always equals acc.
- req  out  1  memory request.
- we  out  1  write strobe, qualified by req.
- halted  out  1  core is in IDLE or HALT.
- illegal  out  1  sticky flag: undefined opcode seen.

Behaviour:
- Reset (asynchronous, active-low) values:
  - State: IDLE.
  - pc=START_ADDR, dptr=0, acc=0, divider count=0.
  - req=0, we=0, illegal=0, halted=1, addrout=START_ADDR.
- Divider:
  - Count runs 0..DIV and wraps to 0; tick=1 when count==DIV.
  - The counter runs in every state.
- Instruction format:
  - opcode = instr[DATA_W-1:DATA_W-4].
  - imm = instr[DATA_W-5:0], zero-extended.
- Opcodes:
  - 0 LOAD: acc<=mem[dptr].
  - 1 STORE: mem[dptr]<=acc.
  - 2 ADDI: acc<=acc+imm.
  - 3 INCP: dptr<=dptr+imm.
  - 4 SETP: dptr<=imm.
  - 5 JMP: pc<=START_ADDR+imm.
  - 6 HALT.
  - 7 NOP.
  - 8-15: behave as NOP and set illegal.
- FSM transitions (all only on tick unless noted):
  - IDLE: if run=1 -> FETCH.
  - FETCH: addrout=pc, req=1, we=0. If ready=1, latch instr -> DECODE; else stay. req stays high until ready.
  - DECODE: req=0.
    - LOAD/STORE -> MEM.
    - HALT -> HALT; pc unchanged.
    - JMP: pc<=START_ADDR+imm.
    - All other opcodes: execute, pc<=pc+1.
    - Non-memory ops then go to FETCH if run=1, else IDLE.
  - MEM: addrout=dptr, req=1, we=1 iff STORE.
    - On ready: LOAD captures datain into acc; pc<=pc+1.
    - Then -> FETCH if run=1, else IDLE.
  - HALT: terminal; leave only by reset.
- Addressing and state outputs:
  - addrout=pc in every state except MEM.
  - halted=1 in IDLE and HALT.
- Arithmetic and wrap rules:
  - acc wraps modulo 2^DATA_W.
  - pc wraps modulo 2^ADDR_W.
  - INCP: if dptr+imm > DATA_LIMIT then dptr<=0. Compare at ADDR_W+1 bits so the carry is not lost.
  - START_ADDR+imm is truncated to ADDR_W.
- Boundary conditions:
  - ready=1 with no tick: ignored; state holds.
  - run falling mid-instruction: the instruction completes, then IDLE.
  - reset_n low mid-MEM: req and we drop immediately (asynchronous); no partial write is required to complete.

Decomposition:
- Shared package accum_pkg holds:
  - opcode localparams (OP_LOAD..OP_NOP).
  - state encodings IDLE/FETCH/DECODE/MEM/HALT.
  - OPC_W=4.
- One natural sub-module, step_divider (parameter DIV, ports clock, reset_n, tick), reused by other paced blocks.

Test Plan:
- DIV=0, ready tied 1; program SETP 5, ADDI 3, STORE, HALT at 9216.. -> mem[5]=3; halted=1; pc=9219; illegal=0.
- DIV=0; mem[7]=0x00AA; program SETP 7, LOAD, ADDI 1, STORE -> mem[7]=0x00AB; exactly one we=1 request.
- DIV=10 -> successive state changes spaced exactly 11 clocks; first FETCH req at clock 11 after run rises.
- dptr=7998, INCP 5 -> dptr=0. JMP 2 -> next fetch addrout=9218.
- ready held 0 for 20 cycles in FETCH -> req stays 1 and addrout stays stable. Opcode 12 -> illegal=1, pc advances by 1.
- Assert reset_n low during a STORE in MEM -> req=0 and we=0 in the same cycle, acc=0; after release, first fetch from 9216.
